hack_ram_arbiter: RTL and testbench
===================================

Name: hack_ram_arbiter

Overview:
Shares the single-port synchronous data RAM (RAM16K + screen + keyboard map) between two requesters: the CPU data port and the video scanout reader.
- Video has default priority to keep scanout on schedule.
- A starvation counter guarantees the CPU a slot after MAX_WAIT consecutive lost cycles.
- Sits between the CPU/video front ends and the RAM macro; tracks read ownership so that each requester gets its own read-data return.

Parameters:
ADDR_WIDTH, 15, RAM word address width (Hack 32K word space)
DATA_WIDTH, 16, data word width
MAX_WAIT, 4, maximum consecutive cycles the CPU may lose arbitration while requesting (must be >= 1)

Ports:
clock  in  1  system clock, all state updates on posedge
reset_n  in  1  synchronous active-low reset
cpu_req  in  1  CPU access request, held with its address/data until granted
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_WIDTH  CPU word address
cpu_wdata  in  DATA_WIDTH  CPU write data
cpu_gnt  out  1  CPU access issued to RAM this cycle
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DATA_WIDTH  CPU read data
vid_req  in  1  video read request (read-only port)
vid_addr  in  ADDR_WIDTH  video word address
vid_gnt  out  1  video access issued this cycle
vid_rvalid  out  1  video read data valid
vid_rdata  out  DATA_WIDTH  video read data
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_WIDTH  RAM address
mem_wdata  out  DATA_WIDTH  RAM write data
mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after a read access

Behaviour:
- Grants are combinational from the requests and the registered state. A transfer completes in any cycle where req && gnt are both high. At most one grant is high per cycle.
- Priority rules:
  - Video wins when both request, unless starve_cnt == MAX_WAIT, in which case the CPU wins.
  - A lone requester always wins.
- starve_cnt (registered, width clog2(MAX_WAIT+1)):
  - increments when cpu_req=1 and cpu_gnt=0;
  - clears when cpu_gnt=1 or cpu_req=0;
  - saturates at MAX_WAIT.
- mem_* outputs mirror the winner's request.
  - mem_en = cpu_gnt | vid_gnt.
  - mem_we = cpu_gnt & cpu_we.
  - mem_wdata = cpu_wdata.
  - With no grant, mem_addr/mem_wdata = 0.
- Read latency is exactly 1 cycle.
  - A registered owner flag records a CPU read grant (cpu_gnt & ~cpu_we) or a video grant.
  - Next cycle: the matching *_rvalid = 1 and *_rdata = mem_rdata.
  - The non-owner's rdata is 0.
  - CPU writes produce no rvalid.
- Back-to-back reads by alternating owners are legal every cycle; each rvalid follows its own grant by one cycle.
- Reset (reset_n=0 sampled at posedge):
  - starve_cnt = 0 and owner flags = 0, so cpu_rvalid and vid_rvalid read 0 the next cycle.
  - While reset_n=0, cpu_gnt, vid_gnt, mem_en and mem_we are forced 0, so no RAM access is issued.
- Reset mid-operation: a read granted in the cycle before reset asserts has its rvalid suppressed. Requesters re-issue after reset.
- Requester protocol: req, addr, we and wdata stay stable while req=1 and gnt=0. Dropping req before grant is allowed and clears starve_cnt.

Decomposition:
- Shared package hack_mem_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH defaults;
  - memory-map constants SCREEN_BASE=0x4000, KBD_ADDR=0x6000;
  - requester enum {REQ_NONE, REQ_CPU, REQ_VID} for the owner register.
- Natural sub-module: hack_rd_tracker. It holds the owner register and performs rvalid/rdata routing, using the existing dff cell per flag.
- Arbitration and starve_cnt stay in the top.

Test Plan:
1. Reset: reset_n=0 for 2 cycles with cpu_req=vid_req=1 -> cpu_gnt=vid_gnt=mem_en=0 and both rvalid=0 throughout; first cycle after release -> vid_gnt=1, mem_addr=vid_addr.
2. CPU alone: write addr 0x0010 data 0x1234 -> cpu_gnt=1, mem_we=1, mem_wdata=0x1234 same cycle, no rvalid. Then read 0x0010 -> cpu_rvalid=1, cpu_rdata=0x1234 one cycle after the grant.
3. Contention (MAX_WAIT=4), both requesting continuously for 10 cycles -> grant pattern V,V,V,V,C,V,V,V,V,C. starve_cnt reaches 4 only before each C.
4. Single-cycle overlap: both assert in cycle 0, vid drops in cycle 1 -> vid_gnt in cycle 0, cpu_gnt in cycle 1, starve_cnt 1 then 0.
5. Alternating reads: video reads 0x4000 in cycle 0, CPU reads 0x0002 in cycle 1 -> vid_rvalid in cycle 1 only, cpu_rvalid in cycle 2 only, each with its own address's data.
6. Reset mid-read: CPU read granted in cycle N, reset_n=0 sampled at end of cycle N -> cpu_rvalid=0 in cycle N+1, no mem_en during reset.

Source files
------------

// File: rtl/hack_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hack_mem_pkg
//  Purpose  : Shared Hack data-memory definitions: bus widths, memory map
//             constants and the read-owner encoding used by the RAM arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package hack_mem_pkg;

    // Default bus widths for the 32K-word Hack data space
    localparam int DEF_ADDR_WIDTH = 15;
    localparam int DEF_DATA_WIDTH = 16;

    // Memory map: RAM16K below SCREEN_BASE, screen buffer, then keyboard
    localparam logic [DEF_ADDR_WIDTH-1:0] SCREEN_BASE = 15'h4000;
    localparam logic [DEF_ADDR_WIDTH-1:0] KBD_ADDR    = 15'h6000;

    // Who owns the read data returning from the RAM this cycle
    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_CPU  = 2'd1,
        REQ_VID  = 2'd2
    } req_owner_e;

    // Width needed to count 0..max_wait inclusive
    function automatic int starve_width(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dff.sv
`default_nettype none
// ============================================================================
//  Module   : dff
//  Purpose  : Generic D flip-flop cell with synchronous active-low clear.
//  Revision : 1.0  initial release
// ============================================================================
module dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Capture input each cycle; clear has priority over new data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/hack_rd_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : hack_rd_tracker
//  Purpose  : Remembers which requester issued last cycle's RAM read and
//             steers the returning RAM data to that requester only.
//  Revision : 1.0  initial release
// ============================================================================
module hack_rd_tracker
    import hack_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_cpu_rd_issue,
    input  logic                  i_vid_rd_issue,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_cpu_rvalid,
    output logic [DATA_WIDTH-1:0] o_cpu_rdata,
    output logic                  o_vid_rvalid,
    output logic [DATA_WIDTH-1:0] o_vid_rdata
);

    logic       r_cpu_own;
    logic       r_vid_own;
    req_owner_e w_owner;

    // One flag per requester; a reset at the issuing edge drops the read
    dff #(.WIDTH(1)) u_cpu_own (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (i_cpu_rd_issue),
        .o_q   (r_cpu_own)
    );

    dff #(.WIDTH(1)) u_vid_own (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (i_vid_rd_issue),
        .o_q   (r_vid_own)
    );

    // Decode the flags into a single owner (grants are exclusive upstream)
    always_comb begin
        w_owner = REQ_NONE;
        if (r_cpu_own) begin
            w_owner = REQ_CPU;
        end else if (r_vid_own) begin
            w_owner = REQ_VID;
        end
    end

    // Route RAM data to the owner; the other side sees zero
    always_comb begin
        o_cpu_rvalid = 1'b0;
        o_cpu_rdata  = '0;
        o_vid_rvalid = 1'b0;
        o_vid_rdata  = '0;
        case (w_owner)
            REQ_CPU: begin
                o_cpu_rvalid = 1'b1;
                o_cpu_rdata  = i_mem_rdata;
            end
            REQ_VID: begin
                o_vid_rvalid = 1'b1;
                o_vid_rdata  = i_mem_rdata;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/hack_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : hack_ram_arbiter
//  Purpose  : Shares the single-port Hack data RAM between the CPU data port
//             and the video scanout reader. Video wins by default; a
//             starvation counter hands the CPU a slot after MAX_WAIT losses.
//  Revision : 1.0  initial release
// ============================================================================
module hack_ram_arbiter
    import hack_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_gnt,
    output logic                  vid_rvalid,
    output logic [DATA_WIDTH-1:0] vid_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int                    c_STARVE_W  = starve_width(MAX_WAIT);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(MAX_WAIT);
    localparam logic [c_STARVE_W-1:0] c_STARVE_ONE = c_STARVE_W'(1);

    logic [c_STARVE_W-1:0] r_starve_cnt;
    logic [c_STARVE_W-1:0] w_starve_nxt;
    logic                  w_cpu_win;
    logic                  w_cpu_gnt;
    logic                  w_vid_gnt;
    logic                  w_any_gnt;

    // Arbitration: video first unless the CPU has waited MAX_WAIT cycles;
    // reset blocks every grant so no RAM access leaks out during reset
    always_comb begin
        w_cpu_win = cpu_req && (!vid_req || (r_starve_cnt == c_STARVE_MAX));
        w_cpu_gnt = reset_n && w_cpu_win;
        w_vid_gnt = reset_n && vid_req && !w_cpu_win;
        w_any_gnt = w_cpu_gnt || w_vid_gnt;
    end

    // Count consecutive lost CPU cycles, saturating; any win or idle clears
    always_comb begin
        w_starve_nxt = '0;
        if (cpu_req && !w_cpu_gnt) begin
            w_starve_nxt = (r_starve_cnt == c_STARVE_MAX) ? c_STARVE_MAX
                                                          : r_starve_cnt + c_STARVE_ONE;
        end
    end

    // Starvation counter register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // Drive the RAM from whichever requester won; idle bus is all-zero
    always_comb begin
        mem_en    = w_any_gnt;
        mem_we    = w_cpu_gnt && cpu_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_cpu_gnt) begin
            mem_addr = cpu_addr;
        end else if (w_vid_gnt) begin
            mem_addr = vid_addr;
        end
        if (w_any_gnt) begin
            mem_wdata = cpu_wdata;
        end
    end

    assign cpu_gnt = w_cpu_gnt;
    assign vid_gnt = w_vid_gnt;

    hack_rd_tracker #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_tracker (
        .clk            (clock),
        .rst_n          (reset_n),
        .i_cpu_rd_issue (w_cpu_gnt && !cpu_we),
        .i_vid_rd_issue (w_vid_gnt),
        .i_mem_rdata    (mem_rdata),
        .o_cpu_rvalid   (cpu_rvalid),
        .o_cpu_rdata    (cpu_rdata),
        .o_vid_rvalid   (vid_rvalid),
        .o_vid_rdata    (vid_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_hack_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hack_ram_arbiter
//  Purpose  : Self-checking bench for hack_ram_arbiter: directed scenarios
//             followed by random CPU/video traffic against a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hack_ram_arbiter;

    localparam int AW       = 15;
    localparam int DW       = 16;
    localparam int MAX_WAIT = 4;

    logic          clock;
    logic          reset_n;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_gnt;
    logic          vid_rvalid;
    logic [DW-1:0] vid_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    hack_ram_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_gnt    (vid_gnt),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM macro stand-in: synchronous single port, read data next cycle
    logic [DW-1:0] ram [0:32767] = '{default: 16'h0000};
    initial mem_rdata = '0;
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Reference model state
    logic [DW-1:0] shadow [0:32767] = '{default: 16'h0000};
    int            m_wait;
    bit            m_cpu_rv, m_vid_rv;
    logic [DW-1:0] m_cpu_rd, m_vid_rd;
    bit            e_cg, e_vg;
    bit            dut_cg;
    bit            chk_en;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One bus cycle: inputs already driven; check at negedge, advance model,
    // optionally assert reset just before the closing edge.
    task automatic step(input bit drop_rst);
        logic [AW-1:0] e_addr;
        @(negedge clock);
        e_cg   = reset_n && cpu_req && (!vid_req || (m_wait == MAX_WAIT));
        e_vg   = reset_n && vid_req && !e_cg;
        e_addr = e_cg ? cpu_addr : (e_vg ? vid_addr : '0);
        dut_cg = cpu_gnt;
        if (chk_en) begin
            check("cpu_gnt",    cpu_gnt,    e_cg);
            check("vid_gnt",    vid_gnt,    e_vg);
            check("mem_en",     mem_en,     e_cg | e_vg);
            check("mem_we",     mem_we,     e_cg & cpu_we);
            check("mem_addr",   mem_addr,   e_addr);
            if (e_cg)       check("mem_wdata", mem_wdata, cpu_wdata);
            else if (!e_vg) check("mem_wdata_idle", mem_wdata, 0);
            check("cpu_rvalid", cpu_rvalid, m_cpu_rv);
            check("cpu_rdata",  cpu_rdata,  m_cpu_rv ? m_cpu_rd : 16'h0);
            check("vid_rvalid", vid_rvalid, m_vid_rv);
            check("vid_rdata",  vid_rdata,  m_vid_rv ? m_vid_rd : 16'h0);
        end
        if (drop_rst) reset_n = 1'b0;
        if (!reset_n) begin
            m_wait   = 0;
            m_cpu_rv = 1'b0;
            m_vid_rv = 1'b0;
        end else begin
            m_wait   = (cpu_req && !e_cg) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
            m_cpu_rv = e_cg && !cpu_we;
            m_vid_rv = e_vg;
            if (m_cpu_rv) m_cpu_rd = shadow[cpu_addr];
            if (m_vid_rv) m_vid_rd = shadow[vid_addr];
            if (e_cg && cpu_we) shadow[cpu_addr] = cpu_wdata;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic cpu_set(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    initial begin
        bit [9:0] pat;
        bit [9:0] pat_exp;
        reset_n = 1'b0;
        chk_en  = 1'b0;
        m_wait  = 0; m_cpu_rv = 1'b0; m_vid_rv = 1'b0;
        m_cpu_rd = '0; m_vid_rd = '0;
        cpu_set(1'b0, 1'b0, '0, '0);
        vid_req = 1'b0; vid_addr = '0;
        step(1'b0);
        chk_en = 1'b1;

        // Reset held with both requesting: no grants, no rvalid
        cpu_set(1'b1, 1'b0, 15'h0005, 16'h0);
        vid_req = 1'b1; vid_addr = 15'h4001;
        step(1'b0);
        step(1'b0);
        reset_n = 1'b1;
        step(1'b0);                       // video wins first cycle out of reset
        cpu_set(1'b0, 1'b0, '0, '0); vid_req = 1'b0;
        step(1'b0);
        step(1'b0);

        // CPU alone: write then read back
        cpu_set(1'b1, 1'b1, 15'h0010, 16'h1234);
        step(1'b0);
        cpu_set(1'b1, 1'b0, 15'h0010, 16'h0);
        step(1'b0);
        cpu_set(1'b0, 1'b0, '0, '0);
        check("t2_rvalid", cpu_rvalid, 1'b1);
        check("t2_rdata",  cpu_rdata,  16'h1234);
        step(1'b0);

        // Continuous contention: V,V,V,V,C,V,V,V,V,C
        cpu_set(1'b1, 1'b0, 15'h0010, 16'h0);
        vid_req = 1'b1; vid_addr = 15'h4000;
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            pat[i] = dut_cg;
            if (e_vg) vid_addr = vid_addr + 15'd1;
        end
        pat_exp = 10'b1000010000;
        check("t3_pattern", {22'd0, pat}, {22'd0, pat_exp});
        cpu_set(1'b0, 1'b0, '0, '0); vid_req = 1'b0;
        step(1'b0);

        // Single-cycle overlap
        cpu_set(1'b1, 1'b0, 15'h0010, 16'h0);
        vid_req = 1'b1; vid_addr = 15'h4002;
        step(1'b0);
        vid_req = 1'b0;
        step(1'b0);
        cpu_set(1'b0, 1'b0, '0, '0);
        step(1'b0);

        // Alternating readers with distinct data
        cpu_set(1'b1, 1'b1, 15'h4000, 16'hBEEF);
        step(1'b0);
        cpu_set(1'b1, 1'b1, 15'h0002, 16'h0ACE);
        step(1'b0);
        cpu_set(1'b0, 1'b0, '0, '0);
        vid_req = 1'b1; vid_addr = 15'h4000;
        step(1'b0);
        vid_req = 1'b0;
        cpu_set(1'b1, 1'b0, 15'h0002, 16'h0);
        check("t5_vid_data", vid_rdata, 16'hBEEF);
        step(1'b0);
        cpu_set(1'b0, 1'b0, '0, '0);
        check("t5_cpu_data", cpu_rdata, 16'h0ACE);
        check("t5_vid_quiet", vid_rvalid, 1'b0);
        step(1'b0);

        // Reset arriving right after a CPU read grant
        cpu_set(1'b1, 1'b0, 15'h0010, 16'h0);
        step(1'b1);
        check("t6_rvalid", cpu_rvalid, 1'b0);
        step(1'b0);
        reset_n = 1'b1;
        cpu_set(1'b0, 1'b0, '0, '0);
        step(1'b0);

        // Random traffic obeying the hold-until-grant protocol
        for (int n = 0; n < 600; n++) begin
            if (!cpu_req || e_cg) begin
                cpu_set(($urandom_range(0, 2) != 0), $urandom_range(0, 1),
                        AW'($urandom_range(0, 31)), DW'($urandom));
                if ($urandom_range(0, 3) == 0) cpu_addr = cpu_addr | 15'h4000;
            end else if ($urandom_range(0, 15) == 0) begin
                cpu_req = 1'b0;
            end
            if (!vid_req || e_vg) begin
                vid_req  = ($urandom_range(0, 3) != 0);
                vid_addr = AW'($urandom_range(0, 31));
                if ($urandom_range(0, 1) == 0) vid_addr = vid_addr | 15'h4000;
            end
            step(1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
